// File: rtl/cdda_stream_buffer.sv
// CD-DA playback ring buffer: byte-wise CPU fill, one stereo frame per consume pulse.
// Optional low-watermark interrupt is built when CDDA_STREAM_IRQ_EN is defined.
module cdda_stream_buffer #(
    parameter int DEPTH_LOG2     = 8,
    parameter bit UNDERFLOW_MUTE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH_LOG2+2:0] sram_a,
    input  logic [7:0]            sram_d_in,
    output logic [7:0]            sram_d_out,
    input  logic                  sram_cs,
    input  logic                  sram_oe,
    input  logic                  sram_we,
    output logic                  sram_wait,
    input  logic                  consume,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic                  dso_enable,
    output logic                  irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 3;

    logic [15:0]           ram_l [DEPTH];
    logic [15:0]           ram_r [DEPTH];
    logic [15:0]           left_q, right_q;
    logic [DEPTH_LOG2-1:0] bufpos, last_valid, fill, frame;
    logic [7:0]            scratch;
    logic                  enabled, underflow;
    logic                  sel_buf, reg_wr, buf_wr;
    logic                  wr_ctrl, wr_pos, wr_lv, wr_scr, wr_wm, wr_ien;
    logic                  at_end, step, uf_set, uf_clr, advance;
    logic [DEPTH_LOG2-1:0] watermark;
    logic                  irq_en, irq_pend;
    logic                  unused_ok;

    assign unused_ok = sram_oe;
    assign sram_wait = 1'b0;

    assign sel_buf = sram_a[AW-1];
    assign reg_wr  = sram_cs & sram_we & ~sel_buf;
    assign buf_wr  = sram_cs & sram_we & sel_buf;
    assign frame   = sram_a[DEPTH_LOG2+1:2];
    assign wr_ctrl = reg_wr && (sram_a[2:0] == 3'd0);
    assign wr_pos  = reg_wr && (sram_a[2:0] == 3'd1);
    assign wr_lv   = reg_wr && (sram_a[2:0] == 3'd2);
    assign wr_scr  = reg_wr && (sram_a[2:0] == 3'd3);
    assign wr_wm   = reg_wr && (sram_a[2:0] == 3'd5);
    assign wr_ien  = reg_wr && (sram_a[2:0] == 3'd6);

    assign fill    = last_valid - bufpos;
    assign at_end  = (bufpos == last_valid);
    assign step    = enabled & consume;
    assign uf_set  = step & at_end;
    assign advance = step & ~at_end;
    assign uf_clr  = wr_ctrl & sram_d_in[1];

`ifdef CDDA_STREAM_IRQ_EN
    logic irq_set;
    // Underflow rising counts only if the CPU is not clearing it this same cycle.
    assign irq_set = (enabled & irq_en & (fill <= watermark)) |
                     (uf_set & ~underflow & ~uf_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            watermark <= '0;
            irq_en    <= 1'b0;
            irq_pend  <= 1'b0;
        end else begin
            if (wr_wm)  watermark <= sram_d_in[DEPTH_LOG2-1:0];
            if (wr_ien) irq_en    <= sram_d_in[0];
            if (irq_set)                       irq_pend <= 1'b1;
            else if (wr_ctrl && sram_d_in[2])  irq_pend <= 1'b0;
        end
    end

    assign irq = irq_pend & irq_en;
`else
    assign watermark = '0;
    assign irq_en    = 1'b0;
    assign irq_pend  = 1'b0;
    assign irq       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            enabled    <= 1'b0;
            dso_enable <= 1'b0;
            underflow  <= 1'b0;
            bufpos     <= '0;
            last_valid <= '0;
            scratch    <= 8'h55;
            left_q     <= '0;
            right_q    <= '0;
        end else begin
            if (wr_ctrl) enabled <= sram_d_in[0];
            // Once disabled, keep the serialiser running until the current frame ends.
            if (enabled)      dso_enable <= 1'b1;
            else if (consume) dso_enable <= 1'b0;
            if (uf_clr)       underflow <= 1'b0;
            else if (uf_set)  underflow <= 1'b1;
            if (wr_pos)       bufpos <= sram_d_in[DEPTH_LOG2-1:0];
            else if (advance) bufpos <= bufpos + 1'b1;
            if (wr_lv)  last_valid <= sram_d_in[DEPTH_LOG2-1:0];
            if (wr_scr) scratch    <= sram_d_in;
            left_q  <= ram_l[bufpos];
            right_q <= ram_r[bufpos];
        end
    end

    // Byte-lane writes; byte 0 of each channel is the high byte.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            if (!sram_a[1]) begin
                if (!sram_a[0]) ram_l[frame][15:8] <= sram_d_in;
                else            ram_l[frame][7:0]  <= sram_d_in;
            end else begin
                if (!sram_a[0]) ram_r[frame][15:8] <= sram_d_in;
                else            ram_r[frame][7:0]  <= sram_d_in;
            end
        end
    end

    always_comb begin
        sram_d_out = 8'h00;
        if (!sel_buf) begin
            case (sram_a[2:0])
                3'd0:    sram_d_out = {5'b0, irq_pend, underflow, enabled};
                3'd1:    sram_d_out = 8'(bufpos);
                3'd2:    sram_d_out = 8'(last_valid);
                3'd3:    sram_d_out = scratch;
                3'd4:    sram_d_out = 8'(fill);
                3'd5:    sram_d_out = 8'(watermark);
                3'd6:    sram_d_out = {7'b0, irq_en};
                default: sram_d_out = 8'h00;
            endcase
        end
    end

    assign left  = (UNDERFLOW_MUTE && underflow) ? 16'h0000 : left_q;
    assign right = (UNDERFLOW_MUTE && underflow) ? 16'h0000 : right_q;
endmodule

// File: tb/tb_cdda_stream_buffer.sv
// Scoreboard bench for cdda_stream_buffer: a depth-256 instance for playback/irq
// and a depth-16 instance for wrap and truncation.
module tb_cdda_stream_buffer;
`ifdef CDDA_STREAM_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [10:0] a = '0;
    logic [7:0]  d = '0;
    logic        cs = 1'b0, we = 1'b0, oe = 1'b1, consume = 1'b0, sel4 = 1'b0;

    logic [7:0]  d_out8, d_out4;
    logic        wait8, wait4, dso8, dso4, irq8, irq4;
    logic [15:0] left8, right8, left4, right4;
    logic [6:0]  a4;
    logic [7:0]  d_out;

    assign a4    = {a[10], a[5:0]};
    assign d_out = sel4 ? d_out4 : d_out8;

    cdda_stream_buffer #(.DEPTH_LOG2(8), .UNDERFLOW_MUTE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .sram_a(a), .sram_d_in(d), .sram_d_out(d_out8),
        .sram_cs(cs & ~sel4), .sram_oe(oe), .sram_we(we), .sram_wait(wait8),
        .consume(consume & ~sel4), .left(left8), .right(right8),
        .dso_enable(dso8), .irq(irq8));

    cdda_stream_buffer #(.DEPTH_LOG2(4), .UNDERFLOW_MUTE(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .sram_a(a4), .sram_d_in(d), .sram_d_out(d_out4),
        .sram_cs(cs & sel4), .sram_oe(oe), .sram_we(we), .sram_wait(wait4),
        .consume(consume & sel4), .left(left4), .right(right4),
        .dso_enable(dso4), .irq(irq4));

    typedef struct { string tag; logic [15:0] val; } exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag; e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [15:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "sb_underrun"; e.val = ~got;
        end else e = sb.pop_front();
        chk(e.tag, got, e.val);
    endtask

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic wr(input logic [10:0] addr, input logic [7:0] data);
        tick(); a = addr; d = data; cs = 1'b1; we = 1'b1;
        tick(); cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [10:0] addr, input logic [15:0] exp, input string tag);
        push(tag, exp);
        a = addr;
        @(negedge clk);
        pop_chk(16'(d_out));
    endtask

    task automatic pulse();
        tick(); consume = 1'b1;
        tick(); consume = 1'b0;
    endtask

    task automatic out_chk(input logic [15:0] l, input logic [15:0] r);
        push("left", l); push("right", r);
        @(negedge clk);
        pop_chk(left8); pop_chk(right8);
    endtask

    task automatic bit_chk(input string tag, input logic got, input logic exp);
        push(tag, 16'(exp));
        @(negedge clk);
        pop_chk(16'(got));
    endtask

    function automatic logic [10:0] fa(input int f, input int ch, input int b);
        return 11'(1024 + f * 4 + ch * 2 + b);
    endfunction

    task automatic load_frame(input int f, input logic [15:0] l, input logic [15:0] r);
        wr(fa(f, 0, 0), l[15:8]); wr(fa(f, 0, 1), l[7:0]);
        wr(fa(f, 1, 0), r[15:8]); wr(fa(f, 1, 1), r[7:0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // Reset values
        rd(0, 16'h00, "rst_ctrl"); rd(1, 16'h00, "rst_bufpos");
        rd(2, 16'h00, "rst_last"); rd(3, 16'h55, "rst_scratch");
        rd(4, 16'h00, "rst_fill");
        out_chk(16'h0, 16'h0);
        bit_chk("rst_dso", dso8, 1'b0);
        bit_chk("rst_irq", irq8, 1'b0);
        bit_chk("wait", wait8, 1'b0);

        // Scratchpad, reg 7, buffer-space reads
        wr(3, 8'hA5);
        rd(3, 16'hA5, "scratch");
        rd(7, 16'h00, "reg7");
        rd(fa(0, 0, 0), 16'h00, "buf_read");

        // Fill frames 0..3 and play
        for (int n = 0; n < 4; n++) load_frame(n, 16'(16'h1000 + n), 16'(16'h2000 + n));
        wr(2, 8'd3);
        rd(4, 16'd3, "fill_3");
        wr(0, 8'h01);
        bit_chk("dso_lag", dso8, 1'b0);
        push("frame0_l", 16'h1000); pop_chk(left8);
        tick();
        bit_chk("dso_on", dso8, 1'b1);
        for (int k = 1; k < 4; k++) begin
            pulse(); tick();
            out_chk(16'(16'h1000 + k), 16'(16'h2000 + k));
        end
        pulse(); tick();
        out_chk(16'h0, 16'h0);
        rd(0, IRQ ? 16'h07 : 16'h03, "uf_status");
        pulse(); tick();
        rd(1, 16'd3, "uf_bufpos");
        out_chk(16'h0, 16'h0);

        // Clear underflow: last frame returns
        wr(0, 8'h07);
        rd(0, 16'h01, "uf_clr_status");
        out_chk(16'h1003, 16'h2003);

        // Disable mid-playback
        wr(2, 8'h10);
        pulse();
        rd(1, 16'd4, "adv_bufpos");
        wr(0, 8'h00);
        repeat (3) tick();
        bit_chk("dso_hold", dso8, 1'b1);
        pulse();
        bit_chk("dso_drop", dso8, 1'b0);
        rd(1, 16'd4, "dis_bufpos");

        // Register write beats same-cycle consume
        wr(0, 8'h01);
        tick(); a = 1; d = 8'h20; cs = 1'b1; we = 1'b1; consume = 1'b1;
        tick(); cs = 1'b0; we = 1'b0; consume = 1'b0;
        rd(1, 16'h20, "wr_beats_consume");
        wr(2, 8'h20);
        tick(); a = 0; d = 8'h03; cs = 1'b1; we = 1'b1; consume = 1'b1;
        tick(); cs = 1'b0; we = 1'b0; consume = 1'b0;
        rd(0, 16'h01, "uf_clr_beats_set");

        // Depth-16 instance: truncation and wrap
        sel4 = 1'b1;
        wr(1, 8'hFF);
        rd(1, 16'h0F, "d4_trunc");
        wr(2, 8'h01);
        wr(0, 8'h01);
        rd(4, 16'd2, "d4_fill_wrap");
        pulse();
        rd(1, 16'h00, "d4_wrap_pos");
        rd(4, 16'd1, "d4_fill");
        sel4 = 1'b0;

        // Watermark interrupt
        wr(1, 8'h00);
        wr(2, 8'h03);
        wr(5, 8'h02);
        wr(6, 8'h01);
        wr(0, 8'h05);
        rd(5, IRQ ? 16'h02 : 16'h00, "wm_read");
        rd(6, IRQ ? 16'h01 : 16'h00, "ien_read");
        bit_chk("irq_idle", irq8, 1'b0);
        pulse();
        rd(4, 16'd2, "irq_fill2");
        tick();
        bit_chk("irq_rise", irq8, IRQ);
        wr(0, 8'h05);
        bit_chk("irq_set_wins", irq8, IRQ);
        wr(2, 8'h06);
        wr(0, 8'h05);
        bit_chk("irq_clr", irq8, 1'b0);
        rd(0, 16'h01, "irq_status");

        // Reset during playback with a consume pulse
        tick(); rst = 1'b1; consume = 1'b1;
        tick(); rst = 1'b0; consume = 1'b0;
        out_chk(16'h0, 16'h0);
        rd(0, 16'h00, "mid_rst_ctrl"); rd(1, 16'h00, "mid_rst_bufpos");
        rd(2, 16'h00, "mid_rst_last"); rd(3, 16'h55, "mid_rst_scratch");
        rd(5, 16'h00, "mid_rst_wm");
        bit_chk("mid_rst_dso", dso8, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdda_stream_buffer.md
# cdda_stream_buffer

Parametrised CD-DA playback buffer between the CPU's SRAM-style register bus and the digital sound output serialiser. It holds a ring of stereo 16-bit frames written byte-wise by the CPU and hands one frame per `consume` pulse to the serialiser. It tracks play position, end-of-valid-data, fill level and underflow. Over the previous generation it adds configurable depth, a fill-level register, mute-on-underflow and an optional low-watermark interrupt.

## Interface
- `DEPTH_LOG2`, 8: ring depth is 2^DEPTH_LOG2 frames; legal range 4..8.
- `UNDERFLOW_MUTE`, 1: 1 = outputs forced to 0 while underflowed; 0 = last frame repeats.
- `clk` in 1: system clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `sram_a` in DEPTH_LOG2+3: bus address. Top bit set selects the buffer. In buffer space, `[DEPTH_LOG2+1:2]` is the frame, `[1]` the channel (0 = L) and `[0]` the byte (0 = high).
- `sram_d_in` in 8: write data.
- `sram_d_out` out 8: read data, combinational from `sram_a`.
- `sram_cs`, `sram_oe`, `sram_we` in 1: bus strobes; a write occurs on any cycle with `cs & we`.
- `sram_wait` out 1: constant 0.
- `consume` in 1: one-cycle pulse from the serialiser at each frame boundary.
- `left`, `right` out 16: current frame to the serialiser.
- `dso_enable` out 1: serialiser enable.
- `irq` out 1: level interrupt (see Configuration).

## Operation
- Register space, top address bit 0, decoded on `a[2:0]`:
  - 0 control/status. Read `{5'b0, irq_pend, underflow, enabled}`. Write: bit0 sets `enabled`; bit1 = 1 clears `underflow`; bit2 = 1 clears `irq_pend`.
  - 1 `bufpos`, R/W.
  - 2 `last_valid`, R/W.
  - 3 scratchpad, R/W.
  - 4 `fill`, read-only: `(last_valid - bufpos) mod 2^DEPTH_LOG2`.
  - 5 `watermark`, R/W.
  - 6 `irq_en`, R/W bit0.
  - 7 reads 0.
- Register widths: `bufpos`, `last_valid`, `watermark` and `fill` are DEPTH_LOG2 bits, zero-extended on read, truncated on write.
- Buffer space: write-only. Reads return 0x00.
- `left`/`right` come from two dual-port RAMs, 2^DEPTH_LOG2 x 16 each, read at `bufpos`.
- While `enabled`, each `consume` does the following:
  - If `bufpos == last_valid`: set `underflow`; `bufpos` holds.
  - Otherwise: `bufpos` increments modulo depth and wraps silently.
- While `underflow && UNDERFLOW_MUTE`, `left`/`right` read 0.
- `dso_enable` rises the cycle after `enabled` rises. After `enabled` falls, it stays high until the next `consume`, then clears, so the current frame finishes.
- Simultaneous events: a CPU write to a register wins over the same-cycle `consume` update, both for `bufpos` and for the underflow set/clear.

## Timing
- Reset values:
  - `enabled` = 0, `dso_enable` = 0, `underflow` = 0, `bufpos` = 0, `last_valid` = 0, scratchpad = 0x55, `watermark` = 0, `irq_en` = 0, `irq_pend` = 0, `irq` = 0.
  - `left`/`right` = 0 until the first RAM read after reset.
  - RAM contents are not reset.
- Register writes take effect at the next clock edge. `sram_d_out` reflects the new value one cycle after the write.
- RAM read latency is 1 cycle. `left`/`right` are valid 1 cycle after a `bufpos` change; the serialiser samples them a full frame later.
- A buffer write to the frame currently at `bufpos` appears on the outputs 1 cycle later.
- Reset asserted mid-playback returns everything to its reset values at the next edge. The `consume` pulse of that cycle is ignored.

## Configuration
- `CDDA_STREAM_IRQ_EN` defined:
  - `irq_pend` sets on any cycle where `enabled && irq_en && fill <= watermark`, or when `underflow` rises.
  - `irq_pend` clears only by a control-register write with bit2 = 1. If the set condition is true in the same cycle, set wins.
  - `irq = irq_pend && irq_en`.
- Not defined: `irq` is tied to 0; registers 5 and 6 and status bit2 read 0; writes to them are ignored.

## Test plan
- Reset, then read registers 0..4 -> 0x00, 0x00, 0x00, 0x55, 0x00.
- Fill frames 0..3 with L = 0x1000+n and R = 0x2000+n, set `last_valid` = 3 and enable, then issue 5 `consume` pulses:
  - outputs step through n = 0..3;
  - the 4th pulse sets `underflow`;
  - with `UNDERFLOW_MUTE` = 1 the outputs read 0;
  - `bufpos` = 3.
- `DEPTH_LOG2` = 4 with `bufpos` = 15, `last_valid` = 1, then `consume` -> `bufpos` = 0; `fill` reads 1.
- Disable during playback -> `dso_enable` stays 1 until the next `consume`, then drops; `bufpos` stops advancing.
- `consume` in the same cycle as a CPU write of `bufpos` = 0x20 -> `bufpos` = 0x20.
- With `CDDA_STREAM_IRQ_EN`, `watermark` = 2, `irq_en` = 1 and `fill` going 3 -> 2:
  - `irq` rises one cycle after `fill` reaches 2;
  - writing control 0x05 with `fill` = 2 leaves `irq` high (set wins);
  - writing control 0x05 with `fill` = 5 drops `irq`.
